// File: rtl/ecc_pkg.sv
// Shared constants for the ECC kP scalar-multiply sequencer: state encodings, op codes, defaults.
package ecc_pkg;

  localparam int K_WIDTH_DEF     = 32;
  localparam int OUT_NIBBLES_DEF = 8;
  localparam int WDT_CYCLES_DEF  = 255;

  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_SCAN     = 4'd1;
  localparam state_t ST_LOAD     = 4'd2;
  localparam state_t ST_DBL_REQ  = 4'd3;
  localparam state_t ST_DBL_WAIT = 4'd4;
  localparam state_t ST_ADD_REQ  = 4'd5;
  localparam state_t ST_ADD_WAIT = 4'd6;
  localparam state_t ST_NEXT     = 4'd7;
  localparam state_t ST_DONE     = 4'd8;
  localparam state_t ST_OUT      = 4'd9;

  // States in which the sequencer is waiting on the point unit.
  function automatic logic is_wdt_state(input state_t s);
    return (s == ST_DBL_REQ) || (s == ST_DBL_WAIT) ||
           (s == ST_ADD_REQ) || (s == ST_ADD_WAIT);
  endfunction

endpackage

// File: rtl/ecc_seq_watchdog.sv
// Per-state stall watchdog: down-counter reloaded on state entry, flags terminal count.
module ecc_seq_watchdog
  import ecc_pkg::*;
#(
  parameter int WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tc
);

  localparam int W = $clog2(WDT_CYCLES + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_restart || !i_en) begin
      cnt_q <= W'(WDT_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign o_tc = i_en && (cnt_q == '0);

endmodule

// File: rtl/ecc_kp_sequencer.sv
// MSB-first double-and-add sequencer for an EC point unit, with nibble output phase.
// Optional stall watchdog when ECC_SEQ_WDT_EN is defined.
//
// state    | meaning
// IDLE     | waiting for i_start
// SCAN     | skipping leading zero bits of k
// LOAD     | R <= P for the leading one bit
// DBL_REQ  | requesting R <= 2R
// DBL_WAIT | waiting for double to finish
// ADD_REQ  | requesting R <= R+P
// ADD_WAIT | waiting for add to finish
// NEXT     | advance to next scalar bit
// DONE     | o_done pulse
// OUT      | stepping o_out_sel over the result nibbles
module ecc_kp_sequencer
  import ecc_pkg::*;
#(
  parameter int K_WIDTH     = K_WIDTH_DEF,
  parameter int OUT_NIBBLES = OUT_NIBBLES_DEF,
  parameter int WDT_CYCLES  = WDT_CYCLES_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [K_WIDTH-1:0] i_k,
  input  logic               i_op_ready,
  input  logic               i_op_done,
  output logic               o_busy,
  output logic               o_load_p,
  output logic               o_op_valid,
  output logic               o_op_sel,
  output logic               o_done,
  output logic               o_inf,
  output logic               o_out_valid,
  output logic [2:0]         o_out_sel,
  output logic               o_err
);

  localparam int         CW       = $clog2(K_WIDTH + 1);
  localparam logic [2:0] OUT_LAST = 3'(OUT_NIBBLES - 1);

  state_t             state_q, state_d, state_raw;
  logic [K_WIDTH-1:0] ks_q;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         out_q;
  logic               inf_q;
  logic               wdt_tc;

  always_comb begin
    state_raw = state_q;
    case (state_q)
      ST_IDLE:     if (i_start) state_raw = ST_SCAN;
      ST_SCAN: begin
        if (ks_q[K_WIDTH-1])        state_raw = ST_LOAD;
        else if (cnt_q == CW'(1))   state_raw = ST_DONE;
      end
      ST_LOAD:     state_raw = (cnt_q == '0) ? ST_DONE : ST_DBL_REQ;
      ST_DBL_REQ:  if (i_op_ready) state_raw = ST_DBL_WAIT;
      ST_DBL_WAIT: if (i_op_done) state_raw = ks_q[K_WIDTH-1] ? ST_ADD_REQ : ST_NEXT;
      ST_ADD_REQ:  if (i_op_ready) state_raw = ST_ADD_WAIT;
      ST_ADD_WAIT: if (i_op_done) state_raw = ST_NEXT;
      ST_NEXT:     state_raw = (cnt_q == CW'(1)) ? ST_DONE : ST_DBL_REQ;
      ST_DONE:     state_raw = ST_OUT;
      ST_OUT:      if (out_q == OUT_LAST) state_raw = ST_IDLE;
      default:     state_raw = ST_IDLE;
    endcase
    state_d = wdt_tc ? ST_IDLE : state_raw;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ks_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      inf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            ks_q  <= i_k;
            cnt_q <= CW'(K_WIDTH);
            inf_q <= 1'b0;
          end
        end
        ST_SCAN: begin
          ks_q  <= {ks_q[K_WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - 1'b1;
          // Ran off the end without a set bit: k was zero.
          if (!ks_q[K_WIDTH-1] && (cnt_q == CW'(1))) inf_q <= 1'b1;
        end
        ST_NEXT: begin
          ks_q  <= {ks_q[K_WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - 1'b1;
        end
        ST_DONE: out_q <= '0;
        ST_OUT:  out_q <= out_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_load_p    = (state_q == ST_LOAD);
  assign o_op_valid  = (state_q == ST_DBL_REQ) || (state_q == ST_ADD_REQ);
  assign o_op_sel    = (state_q == ST_ADD_REQ) ? OP_ADD : OP_DBL;
  assign o_done      = (state_q == ST_DONE);
  assign o_inf       = inf_q;
  assign o_out_valid = (state_q == ST_OUT);
  assign o_out_sel   = (state_q == ST_OUT) ? out_q : 3'd0;

`ifdef ECC_SEQ_WDT_EN
  logic err_q;

  ecc_seq_watchdog #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (is_wdt_state(state_q)),
    .i_restart (state_raw != state_q),
    .o_tc      (wdt_tc)
  );

  // Registered so the pulse lands in the IDLE cycle, clear of o_op_valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= wdt_tc;
  end

  assign o_err = err_q;
`else
  assign wdt_tc = 1'b0;
  assign o_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_kp_sequencer.sv
// Directed, table-driven bench for ecc_kp_sequencer with a simple point-unit responder.
module tb_ecc_kp_sequencer;

  localparam int K_WIDTH     = 32;
  localparam int OUT_NIBBLES = 8;
  localparam int WDT_CYCLES  = 255;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_start;
  logic [K_WIDTH-1:0] i_k;
  logic               i_op_ready;
  logic               i_op_done;
  logic               o_busy, o_load_p, o_op_valid, o_op_sel, o_done, o_inf, o_out_valid, o_err;
  logic [2:0]         o_out_sel;

  ecc_kp_sequencer #(
    .K_WIDTH(K_WIDTH), .OUT_NIBBLES(OUT_NIBBLES), .WDT_CYCLES(WDT_CYCLES)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_k(i_k),
    .i_op_ready(i_op_ready), .i_op_done(i_op_done),
    .o_busy(o_busy), .o_load_p(o_load_p), .o_op_valid(o_op_valid), .o_op_sel(o_op_sel),
    .o_done(o_done), .o_inf(o_inf), .o_out_valid(o_out_valid), .o_out_sel(o_out_sel),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] k;
    int          rdy_dly;
    bit          spur;
    bit          busy_start;
    int          exp_dbl;
    int          exp_add;
    logic [63:0] exp_seq;
    int          exp_load;
    bit          exp_inf;
    int          exp_lat;
    int          exp_run;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] all_outs();
    return {o_busy, o_load_p, o_op_valid, o_op_sel, o_done, o_inf,
            o_out_valid, o_out_sel, o_err};
  endfunction

  task automatic run_txn(input vec_t v, input int idx);
    string       tag;
    int          n_dbl = 0, n_add = 0, n_load = 0, n_done = 0, n_err = 0;
    int          lat = 0, run = 0, max_run = 0, rdy_cnt = 0, out_idx = 0;
    logic [63:0] seq = '0;
    bit          seen_done = 0, inf_at_done = 0, finished = 0;
    bit          done_pend = 0, prev_valid = 0, prev_sel = 0;
    bit          sel_bad = 0, out_bad = 0, excl_bad = 0;
    tag = $sformatf("v%0d", idx);
    i_k = v.k;
    i_start = 1'b1;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge i_clk);
      if ((int'(o_load_p) + int'(o_op_valid) + int'(o_done) + int'(o_out_valid) + int'(o_err)) > 1)
        excl_bad = 1;
      if (o_load_p) n_load++;
      if (o_err) n_err++;
      if (o_busy && !seen_done && !o_done) lat++;
      if (o_done) begin
        n_done++;
        seen_done = 1;
        inf_at_done = o_inf;
      end
      if (o_out_valid) begin
        if (o_out_sel !== 3'(out_idx)) out_bad = 1;
        out_idx++;
      end
      i_op_ready = 1'b0;
      i_op_done  = 1'b0;
      if (done_pend) begin
        i_op_done = 1'b1;
        done_pend = 0;
      end
      if (o_op_valid) begin
        if (prev_valid) begin
          run++;
          if (o_op_sel != prev_sel) sel_bad = 1;
        end else begin
          run = 1;
        end
        if (run > max_run) max_run = run;
        if (rdy_cnt == v.rdy_dly) begin
          i_op_ready = 1'b1;
          rdy_cnt = 0;
          done_pend = 1;
          seq = {seq[62:0], o_op_sel};
          if (o_op_sel) n_add++;
          else          n_dbl++;
        end else begin
          rdy_cnt++;
          if (v.spur) i_op_done = 1'b1;
        end
      end
      prev_valid = o_op_valid;
      prev_sel   = o_op_sel;
      i_start = v.busy_start && o_busy;
      if (seen_done && !o_busy) finished = 1;
    end
    i_start    = 1'b0;
    i_op_ready = 1'b0;
    i_op_done  = 1'b0;
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no completion within cycle budget", tag);
    end
    check({tag, "_dbl"},      64'(n_dbl),       64'(v.exp_dbl));
    check({tag, "_add"},      64'(n_add),       64'(v.exp_add));
    check({tag, "_seq"},      seq,              v.exp_seq);
    check({tag, "_load"},     64'(n_load),      64'(v.exp_load));
    check({tag, "_done"},     64'(n_done),      64'd1);
    check({tag, "_inf"},      64'(inf_at_done), 64'(v.exp_inf));
    check({tag, "_inf_held"}, 64'(o_inf),       64'(v.exp_inf));
    check({tag, "_out_cnt"},  64'(out_idx),     64'(OUT_NIBBLES));
    check({tag, "_out_sel"},  64'(out_bad),     64'd0);
    check({tag, "_excl"},     64'(excl_bad),    64'd0);
    check({tag, "_sel_hold"}, 64'(sel_bad),     64'd0);
    check({tag, "_run"},      64'(max_run),     64'(v.exp_run));
    check({tag, "_err"},      64'(n_err),       64'd0);
    if (v.exp_lat != 0) check({tag, "_lat"}, 64'(lat), 64'(v.exp_lat));
  endtask

  initial begin
    bit done_pend, add_acc;
    i_rst = 1'b1; i_start = 1'b0; i_k = '0; i_op_ready = 1'b0; i_op_done = 1'b0;
    #3;
    check("reset_outs", 64'(all_outs()), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_outs", 64'(all_outs()), 64'd0);

    // k, rdy_dly, spur, busy_start, dbl, add, seq, load, inf, lat, run
    vecs[0] = '{32'd5,         0,  1'b0, 1'b0, 2,  1,  64'b001,               1, 1'b0, 0,  1};
    vecs[1] = '{32'd0,         0,  1'b0, 1'b0, 0,  0,  64'd0,                 0, 1'b1, 32, 0};
    vecs[2] = '{32'd1,         0,  1'b0, 1'b0, 0,  0,  64'd0,                 1, 1'b0, 33, 0};
    vecs[3] = '{32'hFFFFFFFF,  0,  1'b0, 1'b0, 31, 31, 64'h1555555555555555,  1, 1'b0, 0,  1};
    vecs[4] = '{32'd5,         10, 1'b1, 1'b1, 2,  1,  64'b001,               1, 1'b0, 0,  11};
    vecs[5] = '{32'h80000000,  2,  1'b0, 1'b0, 31, 0,  64'd0,                 1, 1'b0, 0,  3};
    vecs[6] = '{32'h0000000A,  0,  1'b0, 1'b1, 3,  1,  64'b0010,              1, 1'b0, 0,  1};

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Reset while parked in ADD_WAIT, then a clean k = 3 run.
    i_k = 32'd5;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    done_pend = 0;
    add_acc = 0;
    for (int c = 0; c < 500 && !add_acc; c++) begin
      @(negedge i_clk);
      i_op_ready = 1'b0;
      i_op_done  = 1'b0;
      if (done_pend) begin
        i_op_done = 1'b1;
        done_pend = 0;
      end
      if (o_op_valid) begin
        i_op_ready = 1'b1;
        if (o_op_sel) add_acc = 1;
        else          done_pend = 1;
      end
    end
    check("rst_add_reached", 64'(add_acc), 64'd1);
    @(negedge i_clk);
    i_op_ready = 1'b0;
    check("rst_in_add_wait", 64'({o_busy, o_op_valid}), 64'b10);
    #2 i_rst = 1'b1;
    #1 check("rst_async_outs", 64'(all_outs()), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run_txn('{32'd3, 0, 1'b0, 1'b0, 1, 1, 64'b01, 1, 1'b0, 0, 1}, 7);

`ifdef ECC_SEQ_WDT_EN
    begin
      int  wait_cnt = 0, n_done_w = 0;
      bit  accepted = 0, err_seen = 0;
      i_k = 32'd2;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      for (int c = 0; c < 2000 && !err_seen; c++) begin
        @(negedge i_clk);
        i_op_ready = 1'b0;
        if (o_done) n_done_w++;
        if (o_err) begin
          err_seen = 1;
          check("wdt_idle_on_err", 64'(o_busy), 64'd0);
        end else if (accepted && o_busy) begin
          wait_cnt++;
        end
        if (o_op_valid && !accepted) begin
          i_op_ready = 1'b1;
          accepted = 1;
        end
      end
      check("wdt_err_seen",  64'(err_seen), 64'd1);
      check("wdt_wait_cyc",  64'(wait_cnt), 64'(WDT_CYCLES));
      check("wdt_no_done",   64'(n_done_w), 64'd0);
      @(negedge i_clk);
      check("wdt_err_pulse", 64'({o_err, o_busy}), 64'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
